// File: rtl/rv32_ctrl_pkg.sv
// ============================================================================
// Module  : rv32_ctrl_pkg
// Brief   : Shared opcodes, immediate encodings, FSM states and static
//           control bundle for the RV32I multi-cycle control sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32_ctrl_pkg;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0] imm_sel;
    logic       alu_src;
    logic       alu_op;
    logic       lui_op;
    logic       wd_src;
    logic       mem2reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Builds a ctrl_t in the same field order the decode table is written in.
  function automatic ctrl_t mk_ctrl(
    input logic [1:0] imm_sel,
    input logic       alu_src,
    input logic       alu_op,
    input logic       lui_op,
    input logic       wd_src,
    input logic       mem2reg
  );
    ctrl_t c;
    c.imm_sel = imm_sel;
    c.alu_src = alu_src;
    c.alu_op  = alu_op;
    c.lui_op  = lui_op;
    c.wd_src  = wd_src;
    c.mem2reg = mem2reg;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uc_decode.sv
// ============================================================================
// Module  : uc_decode
// Brief   : Combinational opcode decoder: selector -> static controls and an
//           illegal-opcode flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uc_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [4:0] i_selector,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_illegal = 1'b0;
    case (i_selector)
      OP_R:      o_ctrl = mk_ctrl(IMM_I, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      OP_I:      o_ctrl = mk_ctrl(IMM_I, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      OP_LOAD:   o_ctrl = mk_ctrl(IMM_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      OP_STORE:  o_ctrl = mk_ctrl(IMM_S, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      OP_BRANCH: o_ctrl = mk_ctrl(IMM_B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      OP_JAL:    o_ctrl = mk_ctrl(IMM_J, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_LUI:    o_ctrl = mk_ctrl(IMM_I, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : RV32I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with a
//           held static-control register and ready-qualified memory handshakes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import rv32_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] selector,
  input  logic       Zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic [1:0] ImmSel,
  output logic       LUIOP,
  output logic       WDSrc,
  output logic       ALUSrc,
  output logic       ALUOP,
  output logic       Mem2Reg,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWriteEn,
  output logic       illegal,
  output logic [2:0] state
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic [4:0] r_op;

  ctrl_t      w_dec_ctrl;
  logic       w_dec_illegal;

  logic       w_imem_req;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_pcsrc;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_illegal;

  uc_decode u_decode (
    .i_selector (selector),
    .o_ctrl     (w_dec_ctrl),
    .o_illegal  (w_dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_ctrl  <= CTRL_NOP;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      // The opcode is only guaranteed valid from DECODE on, so latch it there
      // and steer EXEC/MEM/WB from the held copy.
      if (r_state == ST_DECODE) begin
        r_ctrl <= w_dec_ctrl;
        r_op   <= selector;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_pcsrc    = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ready) begin
          w_irwrite = 1'b1;
          w_next    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_dec_illegal) begin
          w_illegal = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = ST_FETCH;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (r_op)
          OP_BRANCH: begin
            w_pcwrite = 1'b1;
            w_pcsrc   = Zero;
            w_next    = ST_FETCH;
          end
          OP_LOAD, OP_STORE: w_next = ST_MEM;
          default:           w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (r_op == OP_LOAD) begin
          w_memread = 1'b1;
          if (dmem_ready) begin
            w_next = ST_WB;
          end
        end else begin
          w_memwrite = 1'b1;
          if (dmem_ready) begin
            w_pcwrite = 1'b1;
            w_next    = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        w_regwrite = 1'b1;
        w_pcwrite  = 1'b1;
        w_pcsrc    = (r_op == OP_JAL);
        w_next     = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  // Reset kills every strobe combinationally so an aborted access drops at once.
  assign imem_req   = w_imem_req & ~rst;
  assign IRWrite    = w_irwrite  & ~rst;
  assign PCWrite    = w_pcwrite  & ~rst;
  assign PCSrc      = w_pcsrc    & w_pcwrite & ~rst;
  assign MemRead    = w_memread  & ~rst;
  assign MemWrite   = w_memwrite & ~rst;
  assign RegWriteEn = w_regwrite & ~rst;
  assign illegal    = w_illegal  & ~rst;

  assign ImmSel  = r_ctrl.imm_sel;
  assign ALUSrc  = r_ctrl.alu_src;
  assign ALUOP   = r_ctrl.alu_op;
  assign LUIOP   = r_ctrl.lui_op;
  assign WDSrc   = r_ctrl.wd_src;
  assign Mem2Reg = r_ctrl.mem2reg;
  assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Cycle-by-cycle scoreboard bench for multicycle_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] selector;
  logic       Zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req, IRWrite, PCWrite, PCSrc;
  logic [1:0] ImmSel;
  logic       LUIOP, WDSrc, ALUSrc, ALUOP, Mem2Reg;
  logic       MemRead, MemWrite, RegWriteEn, illegal;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .selector   (selector),
    .Zero       (Zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .ImmSel     (ImmSel),
    .LUIOP      (LUIOP),
    .WDSrc      (WDSrc),
    .ALUSrc     (ALUSrc),
    .ALUOP      (ALUOP),
    .Mem2Reg    (Mem2Reg),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWriteEn (RegWriteEn),
    .illegal    (illegal),
    .state      (state)
  );

  // Expected vector: {state, imem_req, IRWrite, PCWrite, PCSrc,
  //                   ImmSel, LUIOP, WDSrc, ALUSrc, ALUOP, Mem2Reg,
  //                   MemRead, MemWrite, RegWriteEn, illegal}
  typedef struct {
    logic        rst;
    logic        ir;
    logic        dr;
    logic        z;
    logic [4:0]  sel;
    logic [17:0] exp;
    string       tag;
  } cyc_t;

  cyc_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] prev_ctrl;

  // {ImmSel, LUIOP, WDSrc, ALUSrc, ALUOP, Mem2Reg}
  function automatic logic [6:0] dec(input logic [4:0] s);
    case (s)
      5'b01100: return 7'b00_0_0_0_1_0;
      5'b00100: return 7'b00_0_0_1_1_0;
      5'b00000: return 7'b00_0_0_1_0_1;
      5'b01000: return 7'b01_0_0_1_0_0;
      5'b11000: return 7'b10_0_0_0_1_0;
      5'b11011: return 7'b11_0_1_0_0_0;
      5'b01101: return 7'b00_1_0_1_0_0;
      default:  return 7'b0;
    endcase
  endfunction

  function automatic bit legal(input logic [4:0] s);
    return (s == 5'b01100) || (s == 5'b00100) || (s == 5'b00000) ||
           (s == 5'b01000) || (s == 5'b11000) || (s == 5'b11011) ||
           (s == 5'b01101);
  endfunction

  function automatic logic [17:0] mk(input logic [2:0] st, input logic [6:0] c,
                                     input logic ireq, input logic irw,
                                     input logic pcw, input logic pcs,
                                     input logic mr, input logic mw,
                                     input logic rw, input logic ill);
    return {st, ireq, irw, pcw, pcs, c, mr, mw, rw, ill};
  endfunction

  task automatic push(input logic r, input logic ir, input logic dr, input logic z,
                      input logic [4:0] sel, input logic [17:0] exp, input string tag);
    cyc_t e;
    e.rst = r; e.ir = ir; e.dr = dr; e.z = z; e.sel = sel; e.exp = exp; e.tag = tag;
    q.push_back(e);
  endtask

  // Expected trace of one instruction; ready lines are held high outside
  // their request windows to show they are ignored there.
  task automatic push_instr(input logic [4:0] sel, input logic z, input int iw,
                            input int dw, input string tag);
    logic [6:0] c;
    bit ill, ld, stq, br, jal;
    ill = !legal(sel);
    c   = dec(sel);
    ld  = (sel == 5'b00000);
    stq = (sel == 5'b01000);
    br  = (sel == 5'b11000);
    jal = (sel == 5'b11011);
    for (int i = 0; i < iw; i++)
      push(0, 0, 1, ~z, ~sel, mk(3'd0, prev_ctrl, 1, 0, 0, 0, 0, 0, 0, 0), {tag, "_fetchwait"});
    push(0, 1, 1, ~z, ~sel, mk(3'd0, prev_ctrl, 1, 1, 0, 0, 0, 0, 0, 0), {tag, "_fetch"});
    push(0, 1, 1, ~z, sel, mk(3'd1, prev_ctrl, 0, 0, ill, 0, 0, 0, 0, ill), {tag, "_decode"});
    prev_ctrl = ill ? 7'b0 : c;
    if (ill) return;
    if (br) begin
      push(0, 1, 1, z, sel, mk(3'd2, c, 0, 0, 1, z, 0, 0, 0, 0), {tag, "_exec"});
      return;
    end
    push(0, 1, 1, z, sel, mk(3'd2, c, 0, 0, 0, 0, 0, 0, 0, 0), {tag, "_exec"});
    if (ld || stq) begin
      for (int i = 0; i < dw; i++)
        push(0, 1, 0, z, sel, mk(3'd3, c, 0, 0, 0, 0, ld, stq, 0, 0), {tag, "_memwait"});
      push(0, 1, 1, z, sel, mk(3'd3, c, 0, 0, stq, 0, ld, stq, 0, 0), {tag, "_mem"});
      if (stq) return;
    end
    push(0, 1, 1, z, sel, mk(3'd4, c, 0, 0, 1, jal, 0, 0, 1, 0), {tag, "_wb"});
  endtask

  task automatic run_queue();
    cyc_t        e;
    logic [17:0] obs;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      rst        = e.rst;
      imem_ready = e.ir;
      dmem_ready = e.dr;
      Zero       = e.z;
      selector   = e.sel;
      #1;
      obs = {state, imem_req, IRWrite, PCWrite, PCSrc, ImmSel, LUIOP, WDSrc,
             ALUSrc, ALUOP, Mem2Reg, MemRead, MemWrite, RegWriteEn, illegal};
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%05h expected=%05h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    logic [6:0] lc;
    rst        = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    Zero       = 1'b0;
    selector   = 5'b0;
    prev_ctrl  = 7'b0;

    push(1, 1, 1, 0, 5'b0, mk(3'd0, 7'b0, 0, 0, 0, 0, 0, 0, 0, 0), "reset0");
    push(1, 1, 1, 0, 5'b0, mk(3'd0, 7'b0, 0, 0, 0, 0, 0, 0, 0, 0), "reset1");
    run_queue();

    push_instr(5'b00100, 1'b0, 0, 0, "addi");
    push_instr(5'b00000, 1'b0, 0, 2, "load_w2");
    push_instr(5'b11000, 1'b1, 0, 0, "beq_taken");
    push_instr(5'b11000, 1'b0, 0, 0, "beq_nottaken");
    push_instr(5'b11011, 1'b0, 0, 0, "jal");
    push_instr(5'b01000, 1'b0, 0, 0, "store");
    push_instr(5'b11111, 1'b0, 0, 0, "illegal");
    push_instr(5'b01100, 1'b1, 2, 0, "rtype_iw2");
    push_instr(5'b01101, 1'b0, 0, 0, "lui");
    push_instr(5'b01000, 1'b1, 1, 1, "store_w1");
    push_instr(5'b00000, 1'b1, 0, 0, "load_w0");
    run_queue();

    // Reset lands while a LOAD waits in MEM; a coincident dmem_ready is ignored.
    lc = dec(5'b00000);
    push(0, 1, 1, 0, 5'b11111, mk(3'd0, prev_ctrl, 1, 1, 0, 0, 0, 0, 0, 0), "rld_fetch");
    push(0, 1, 1, 0, 5'b00000, mk(3'd1, prev_ctrl, 0, 0, 0, 0, 0, 0, 0, 0), "rld_decode");
    push(0, 1, 1, 0, 5'b00000, mk(3'd2, lc, 0, 0, 0, 0, 0, 0, 0, 0), "rld_exec");
    push(0, 1, 0, 0, 5'b00000, mk(3'd3, lc, 0, 0, 0, 0, 1, 0, 0, 0), "rld_memwait");
    push(1, 1, 1, 0, 5'b00000, mk(3'd3, lc, 0, 0, 0, 0, 0, 0, 0, 0), "rld_rst_inmem");
    push(1, 1, 1, 0, 5'b00000, mk(3'd0, 7'b0, 0, 0, 0, 0, 0, 0, 0, 0), "rld_rst_held");
    prev_ctrl = 7'b0;
    push(0, 0, 1, 0, 5'b00000, mk(3'd0, 7'b0, 1, 0, 0, 0, 0, 0, 0, 0), "rld_release");
    push_instr(5'b00100, 1'b0, 0, 0, "addi_after_rst");
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, driving the datapath strobes from the current state. Holds the decoded static controls (ImmSel, ALUSrc, ...) in a register from DECODE until the instruction retires. Handshakes with instruction and data memories that may insert wait states.

## Interface
- No parameters.
- clk  in  1  core clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- selector  in  5  opcode[6:2] from the instruction register. Valid from the DECODE cycle onward.
- Zero  in  1  ALU zero flag. Sampled only in EXEC for branches.
- imem_ready  in  1  instruction memory has data. Honoured only while imem_req=1.
- dmem_ready  in  1  data memory access complete. Honoured only while MemRead or MemWrite is 1.
- imem_req  out  1  instruction fetch request.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  update PC.
- PCSrc  out  1  PC source: 0 = PC+4, 1 = PC+imm.
- ImmSel  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- LUIOP  out  1  select the upper-immediate path.
- WDSrc  out  1  register write data: 1 = PC+4.
- ALUSrc  out  1  ALU operand B: 1 = immediate.
- ALUOP  out  1  ALU operation: 1 = funct-controlled, 0 = add.
- Mem2Reg  out  1  register write data from memory.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- RegWriteEn  out  1  register file write enable.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 are unreachable and recover to FETCH.
- Supported selector values:
  - R-type 01100
  - I-ALU 00100
  - LOAD 00000
  - STORE 01000
  - BRANCH 11000
  - JAL 11011
  - LUI 01101
  - Any other value is illegal.
- Decoded control values (ImmSel/ALUSrc/ALUOP/LUIOP/WDSrc/Mem2Reg):
  - R: 00/0/1/0/0/0
  - I-ALU: 00/1/1/0/0/0
  - LOAD: 00/1/0/0/0/1
  - STORE: 01/1/0/0/0/0
  - BRANCH: 10/0/1/0/0/0
  - JAL: 11/0/0/0/1/0
  - LUI: 00/1/0/1/0/0
  - Illegal: all fields 0.
- The control register loads the decoder output at the end of DECODE and holds it until the next DECODE.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: IRWrite=1 in that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Capture the control register.
  - Illegal opcode: illegal=1, PCWrite=1, PCSrc=0, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - BRANCH: PCWrite=1, PCSrc=Zero, go to FETCH.
  - LOAD/STORE: go to MEM.
  - R, I-ALU, LUI, JAL: go to WB.
- MEM:
  - LOAD: MemRead=1 held until dmem_ready=1, then go to WB.
  - STORE: MemWrite=1 held until dmem_ready=1. In the ready cycle PCWrite=1, PCSrc=0, go to FETCH.
- WB:
  - RegWriteEn=1, PCWrite=1.
  - PCSrc=1 for JAL, otherwise 0.
  - Go to FETCH.
- Strobes (imem_req, IRWrite, PCWrite, MemRead, MemWrite, RegWriteEn, illegal) are 0 in every state/opcode not listed above.
- PCSrc is 0 whenever PCWrite=0.

## Timing
- Reset:
  - rst=1 at an edge gives state=FETCH and control register 0.
  - All strobes are gated to 0 while rst=1, including imem_req.
  - rst asserted mid-instruction aborts it. Any pending memory request drops in the same cycle, and no PCWrite/RegWriteEn is issued.
- Strobes are Moore outputs of state and control register, except the ready-qualified strobes: IRWrite, and PCWrite for STORE in MEM.
- Cycles per instruction with zero wait states:
  - BRANCH 3
  - R/I/LUI/JAL 4
  - STORE 4
  - LOAD 5
  - Each wait cycle adds 1.
- imem_ready/dmem_ready arriving with no request pending is ignored. A ready coinciding with rst is ignored.
- Exactly one PCWrite pulse per retired or skipped instruction. At most one RegWriteEn pulse per instruction.

## Structure
- Shared package rv32_ctrl_pkg holds:
  - the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI);
  - the ImmSel encodings;
  - the state enum;
  - a packed ctrl_t struct for the six static fields.
- One sub-module: uc_decode, purely combinational, mapping selector to ctrl_t plus an illegal flag.
- multicycle_ctrl contains the FSM, the control register and the strobe logic.

## Test plan
- ADDI (selector 00100), ready always 1 → states 0,1,2,4. In WB: RegWriteEn=1, ALUSrc=1, ALUOP=1, PCWrite=1, PCSrc=0. Total 4 cycles.
- LOAD with dmem_ready low 2 cycles → MemRead=1 for 3 cycles, then WB with Mem2Reg=1, RegWriteEn=1. Total 7 cycles.
- BRANCH with Zero=1, then again with Zero=0 → EXEC issues PCWrite=1 with PCSrc=1, then PCSrc=0. RegWriteEn never asserts.
- JAL (11011), then STORE (01000) → JAL WB: WDSrc=1, PCSrc=1, ImmSel=11. STORE: MemWrite=1, ImmSel=01, no RegWriteEn, 4 cycles.
- selector 11111 → illegal=1 in DECODE, PCWrite=1, PCSrc=0, back to FETCH. Control register is 0.
- rst=1 in MEM of a LOAD with dmem_ready=0 → next cycle state=0, MemRead=0, all strobes 0 while rst=1. After release, imem_req=1.
